// File: rtl/duty_pkg.sv
// Shared types and limits for the duty-cycle ramp and the downstream PWM stage.
package duty_pkg;

  localparam int DUTY_W   = 7;
  localparam int DUTY_MAX = 100;

  typedef enum logic [1:0] {
    IDLE,
    RAMP_UP,
    RAMP_DOWN
  } ramp_state_t;

endpackage

// File: rtl/duty_ramp_period_ticker.sv
// PWM period counter: free-runs 0..C_TIMERLIM-1 while en is high, emits tick on the last clock.
module period_ticker #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned C_TIMERLIM = CLK_FREQ / PWM_FREQ;
  localparam logic [31:0] CNT_LAST   = 32'(C_TIMERLIM - 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (!en || (cnt_q == CNT_LAST)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Gated by rst so the tick is quiet during reset even for a one-clock period.
  assign tick = rst & en & (cnt_q == CNT_LAST);

endmodule

// File: rtl/duty_ramp.sv
// Slew-limited duty-cycle generator feeding the PWM stage; steps toward the target once per period.
// Optional build macro DUTY_RAMP_RETARGET_EN allows a new target to be accepted mid-ramp.
module duty_ramp
  import duty_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned PWM_FREQ = 1000,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DUTY_MAX = duty_pkg::DUTY_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  input  logic [DUTY_W-1:0] target_i,
  input  logic              target_valid_i,
  output logic              target_ready_o,
  output logic [DUTY_W-1:0] duty_cycle_o,
  output logic              period_tick_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [DUTY_W:0]   STEP_8   = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W-1:0] DUTY_CAP = DUTY_W'(DUTY_MAX);

  ramp_state_t       state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic              done_q, done_d;
  logic              tick;
  logic              can_accept;
  logic              accept;
  logic [DUTY_W-1:0] target_clamped;

  // Widened by one bit so duty + STEP cannot wrap before the clamp.
  function automatic logic [DUTY_W-1:0] step_up(input logic [DUTY_W-1:0] d,
                                               input logic [DUTY_W-1:0] t);
    logic [DUTY_W:0] sum;
    sum = {1'b0, d} + STEP_8;
    return (sum >= {1'b0, t}) ? t : sum[DUTY_W-1:0];
  endfunction

  // Signed difference so a step larger than duty cannot underflow past the target.
  function automatic logic [DUTY_W-1:0] step_down(input logic [DUTY_W-1:0] d,
                                                 input logic [DUTY_W-1:0] t);
    logic signed [DUTY_W+1:0] diff;
    diff = $signed({2'b00, d}) - $signed({1'b0, STEP_8});
    return (diff <= $signed({2'b00, t})) ? t : diff[DUTY_W-1:0];
  endfunction

  period_ticker #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ)
  ) u_ticker (
    .clk  (clk),
    .rst  (rst),
    .en   (enable_i),
    .tick (tick)
  );

`ifdef DUTY_RAMP_RETARGET_EN
  assign can_accept = 1'b1;
`else
  assign can_accept = (state_q == IDLE);
`endif

  assign target_ready_o = rst & enable_i & can_accept;
  assign accept         = target_valid_i & target_ready_o;
  assign target_clamped = (target_i > DUTY_CAP) ? DUTY_CAP : target_i;

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    target_d = target_q;
    done_d   = 1'b0;
    if (!enable_i) begin
      state_d = IDLE;
      duty_d  = '0;
    end else if (accept) begin
      // A tick coinciding with accept is deliberately dropped; stepping starts next period.
      target_d = target_clamped;
      if (target_clamped > duty_q) begin
        state_d = RAMP_UP;
      end else if (target_clamped < duty_q) begin
        state_d = RAMP_DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (tick) begin
      case (state_q)
        RAMP_UP: begin
          duty_d = step_up(duty_q, target_q);
          if (duty_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        RAMP_DOWN: begin
          duty_d = step_down(duty_q, target_q);
          if (duty_d == target_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      done_q   <= done_d;
    end
  end

  assign duty_cycle_o  = duty_q;
  assign period_tick_o = tick;
  assign busy_o        = (state_q != IDLE);
  assign done_o        = done_q;

endmodule

// File: tb/tb_duty_ramp.sv
// Scoreboard bench for duty_ramp: stimulus queues expected duty steps, a negedge monitor checks them.
module tb_duty_ramp;

  localparam int CLK_FREQ = 1000;
  localparam int PWM_FREQ = 100;
  localparam int STEP     = 10;
  localparam int LIM      = CLK_FREQ / PWM_FREQ;
  localparam int DMAX     = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable_i = 1'b0;
  logic [6:0] target_i = '0;
  logic       target_valid_i = 1'b0;
  logic       target_ready_o;
  logic [6:0] duty_cycle_o;
  logic       period_tick_o;
  logic       busy_o;
  logic       done_o;

  duty_ramp #(
    .CLK_FREQ (CLK_FREQ),
    .PWM_FREQ (PWM_FREQ),
    .STEP     (STEP),
    .DUTY_MAX (DMAX)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .target_i       (target_i),
    .target_valid_i (target_valid_i),
    .target_ready_o (target_ready_o),
    .duty_cycle_o   (duty_cycle_o),
    .period_tick_o  (period_tick_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];
  int done_q[$];
  int m_duty = 0;
  bit abort_pending = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: list every duty value from start to the clamped target, moving by at most STEP.
  task automatic model_ramp(input int start, input int t);
    int tt;
    int d;
    tt = (t > DMAX) ? DMAX : t;
    d  = start;
    while (d != tt) begin
      if (tt > d) d = (d + STEP > tt) ? tt : d + STEP;
      else        d = (d - STEP < tt) ? tt : d - STEP;
      exp_q.push_back(d);
    end
    done_q.push_back(tt);
    m_duty = tt;
  endtask

  // Monitor
  int cyc = 0;
  int prev_duty = 0;
  bit prev_tick = 1'b0;
  int last_tick = -1;

  always @(negedge clk) begin
    cyc++;
    if (int'(duty_cycle_o) != prev_duty) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_duty_change", int'(duty_cycle_o), prev_duty);
      end else begin
        chk("duty_step", int'(duty_cycle_o), exp_q.pop_front());
        if (!abort_pending) chk("update_after_tick", int'(prev_tick), 1);
      end
      if (abort_pending && duty_cycle_o == 7'd0) abort_pending = 1'b0;
      prev_duty = int'(duty_cycle_o);
    end
    if (done_o) begin
      if (done_q.size() == 0) chk("unexpected_done", int'(done_o), 0);
      else chk("done_duty", int'(duty_cycle_o), done_q.pop_front());
    end
    if (period_tick_o) begin
      if (last_tick >= 0) chk("tick_period", cyc - last_tick, LIM);
      last_tick = cyc;
    end
    if (!enable_i || !rst) last_tick = -1;
    prev_tick = period_tick_o;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int t);
    int n;
    n = 0;
    while (!target_ready_o && n < 200) begin
      step();
      n++;
    end
    if (!target_ready_o) chk("ready_timeout", int'(target_ready_o), 1);
    model_ramp(m_duty, t);
    target_i = 7'(t);
    target_valid_i = 1'b1;
    step();
    target_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || busy_o) && n < 500) begin
      step();
      n++;
    end
    chk("ramp_finishes", exp_q.size() + done_q.size() + int'(busy_o), 0);
  endtask

  task automatic wait_duty(input int v);
    int n;
    n = 0;
    while (int'(duty_cycle_o) != v && n < 200) begin
      step();
      n++;
    end
    chk("reach_duty", int'(duty_cycle_o), v);
  endtask

  task automatic abort_expect();
    exp_q.delete();
    done_q.delete();
    exp_q.push_back(0);
    abort_pending = 1'b1;
  endtask

  initial begin
    int t;
    int nticks;
    enable_i = 1'b1;
    rst = 1'b0;
    repeat (3) step();
    chk("reset_duty",  int'(duty_cycle_o), 0);
    chk("reset_tick",  int'(period_tick_o), 0);
    chk("reset_busy",  int'(busy_o), 0);
    chk("reset_done",  int'(done_o), 0);
    chk("reset_ready", int'(target_ready_o), 0);
    rst = 1'b1;
    step();
    chk("idle_ready", int'(target_ready_o), 1);

    // Ramp up to 30, then down to 5 (last step clamps).
    send(30);
    chk("busy_during_ramp", int'(busy_o), 1);
`ifdef DUTY_RAMP_RETARGET_EN
    chk("ready_during_ramp", int'(target_ready_o), 1);
`else
    chk("ready_during_ramp", int'(target_ready_o), 0);
`endif
    wait_idle();
    chk("final_30", int'(duty_cycle_o), 30);
    send(5);
    wait_idle();
    chk("final_5", int'(duty_cycle_o), 5);

    // Oversized target clamps to 100.
    send(127);
    wait_idle();
    chk("final_clamped", int'(duty_cycle_o), 100);

    // Equal target: no ramp, one done pulse.
    send(100);
    chk("equal_busy0", int'(busy_o), 0);
    step();
    chk("equal_busy1", int'(busy_o), 0);
    wait_idle();
    send(0);
    wait_idle();
    send(0);
    chk("equal0_busy", int'(busy_o), 0);
    wait_idle();

    // Enable drop mid-ramp.
    send(80);
    wait_duty(40);
    abort_expect();
    enable_i = 1'b0;
    step();
    chk("drop_duty", int'(duty_cycle_o), 0);
    chk("drop_busy", int'(busy_o), 0);
    chk("drop_ready", int'(target_ready_o), 0);
    nticks = 0;
    for (int i = 0; i < 2 * LIM; i++) begin
      nticks += int'(period_tick_o);
      step();
    end
    chk("no_ticks_disabled", nticks, 0);
    enable_i = 1'b1;
    m_duty = 0;
    step();
    chk("reenable_ready", int'(target_ready_o), 1);

`ifdef DUTY_RAMP_RETARGET_EN
    send(80);
    wait_duty(50);
    exp_q.delete();
    done_q.delete();
    model_ramp(50, 20);
    target_i = 7'd20;
    target_valid_i = 1'b1;
    step();
    target_valid_i = 1'b0;
    wait_idle();
    chk("retarget_final", int'(duty_cycle_o), 20);
`endif

    // Randomized targets.
    for (int i = 0; i < 10; i++) begin
      t = int'($urandom_range(0, 127));
      send(t);
      wait_idle();
      chk("random_final", int'(duty_cycle_o), (t > DMAX) ? DMAX : t);
    end

    // Asynchronous reset between edges mid-ramp.
    send((m_duty >= 50) ? 0 : 100);
    if (exp_q.size() > 1) begin
      step();
      wait_duty(exp_q[0]);
    end
    abort_expect();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_duty",  int'(duty_cycle_o), 0);
    chk("async_busy",  int'(busy_o), 0);
    chk("async_done",  int'(done_o), 0);
    chk("async_ready", int'(target_ready_o), 0);
    chk("async_tick",  int'(period_tick_o), 0);
    step();
    rst = 1'b1;
    m_duty = 0;
    repeat (2) step();

    chk("queues_drained", exp_q.size() + done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
